// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - oversampling UART receive front end
//
// Purpose: synchronises the raw serial line, qualifies the start bit at its
// middle, strobes mid-bit sample points, deserialises DATA_BITS LSB-first,
// optionally checks parity, checks STOP_BITS stop bits, and presents the word
// with a one-cycle valid pulse plus error flags.
//
// Ports:
//   sample_clk  in   oversampling clock (SAMPLE_RATIO cycles per bit)
//   rst_n       in   asynchronous active-low reset
//   din         in   raw serial line, idle high, asynchronous
//   sample_sig  out  one-cycle strobe at each data/parity/stop sample point
//   data        out  last received word, held until the next frame completes
//   data_valid  out  one-cycle pulse when a frame completes
//   parity_err  out  parity mismatch, qualified by data_valid
//   frame_err   out  a sampled stop bit was 0, qualified by data_valid
//   busy        out  receiver is not idle
//
// Optional feature: define MAJORITY_VOTE_EN to take each data/parity/stop bit
// as the 2-of-3 majority around the sample point (commit one cycle later).

module uart_rx_sampler #(
  parameter int SAMPLE_RATIO = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sample_clk,
  input  logic                 rst_n,
  input  logic                 din,
  output logic                 sample_sig,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(SAMPLE_RATIO);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATIO - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE_RATIO / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_sync1;
  logic                 r_din_s;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_sidx;
  logic [DATA_BITS-1:0] r_word;
  logic                 r_perr_n;
  logic                 r_ferr_n;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;

  logic          w_in_bit_state;
  logic          w_samp;
  logic          w_stop_last;
  logic [CW-1:0] w_cnt_next;
  logic          w_commit;
  logic          w_bit;
  state_t        w_kind;
  logic          w_last;

  assign w_in_bit_state = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_samp         = w_in_bit_state && (r_cnt == CNT_LAST);
  assign w_stop_last    = (STOP_BITS == 1) || r_sidx;
  assign w_cnt_next     = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

`ifdef MAJORITY_VOTE_EN
  localparam logic [CW-1:0] CNT_PRE = CW'(SAMPLE_RATIO - 2);

  // Votes are collected at SR-2 and SR-1; the third sample is the line on the
  // edge after the strobe, so the bit lands one cycle after sample_sig.
  logic   r_v0;
  logic   r_v1;
  logic   r_pend;
  state_t r_pkind;
  logic   r_plast;

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0    <= 1'b1;
      r_v1    <= 1'b1;
      r_pend  <= 1'b0;
      r_pkind <= S_IDLE;
      r_plast <= 1'b0;
    end else begin
      if (w_in_bit_state && (r_cnt == CNT_PRE)) r_v0 <= r_din_s;
      r_pend <= w_samp;
      if (w_samp) begin
        r_v1    <= r_din_s;
        r_pkind <= r_state;
        r_plast <= (r_state == S_STOP) && w_stop_last;
      end
    end
  end

  assign w_commit = r_pend;
  assign w_bit    = (r_v0 & r_v1) | (r_v0 & r_din_s) | (r_v1 & r_din_s);
  assign w_kind   = r_pkind;
  assign w_last   = r_plast;
`else
  assign w_commit = w_samp;
  assign w_bit    = r_din_s;
  assign w_kind   = r_state;
  assign w_last   = (r_state == S_STOP) && w_stop_last;
`endif

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_din_s  <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_sidx   <= 1'b0;
      r_word   <= '0;
      r_perr_n <= 1'b0;
      r_ferr_n <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_din_s <= r_sync1;
      r_valid <= 1'b0;

      // Bit commit: LSB-first shift so the first data bit ends up in bit 0.
      if (w_commit) begin
        case (w_kind)
          S_DATA:   r_word   <= {w_bit, r_word[DATA_BITS-1:1]};
          S_PARITY: r_perr_n <= (((^r_word) ^ w_bit) != PAR_ODD);
          S_STOP:   if (!w_bit) r_ferr_n <= 1'b1;
          default:  ;
        endcase
        if (w_last) begin
          r_data  <= r_word;
          r_valid <= 1'b1;
          r_perr  <= r_perr_n;
          r_ferr  <= r_ferr_n | ~w_bit;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (!r_din_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (r_cnt == CNT_HALF) begin
            if (!r_din_s) begin
              r_state  <= S_DATA;
              r_cnt    <= '0;
              r_idx    <= '0;
              r_sidx   <= 1'b0;
              r_perr_n <= 1'b0;
              r_ferr_n <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          r_cnt <= w_cnt_next;
          if (w_samp) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == IDX_LAST) r_state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          r_cnt <= w_cnt_next;
          if (w_samp) r_state <= S_STOP;
        end
        S_STOP: begin
          r_cnt <= w_cnt_next;
          if (w_samp && !w_stop_last) r_sidx <= 1'b1;
          // A low final stop bit means the line may be held low (break);
          // wait for it to return high before looking for another start.
          if (w_commit && w_last) r_state <= w_bit ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (r_din_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sample_sig = w_samp;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Parametrised successor to the single-purpose start-bit sampler: a full oversampling UART receive front end.
- Synchronises `din`, qualifies the start bit, emits mid-bit sample strobes, and deserialises DATA_BITS LSB-first.
- Optionally checks parity; checks stop bit(s).
- Presents a parallel word with one-cycle valid and error flags. Sits between the pin and the transceiver's RX buffer.

Parameters:
- SAMPLE_RATIO, 16, sample_clk cycles per bit; even, 4..256.
- DATA_BITS, 8, data bits per frame; 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- sample_clk  in  1  oversampling clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  raw serial line; idle high; asynchronous to sample_clk.
- sample_sig  out  1  high for one cycle at each data/parity/stop mid-bit sample point.
- data  out  DATA_BITS  last received word, LSB = first bit; held until next frame completes.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  valid while data_valid=1; parity mismatch; always 0 when PARITY_MODE=0.
- frame_err  out  1  valid while data_valid=1; any sampled stop bit was 0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters=0; sync flops=1.
  - data=0; data_valid, parity_err, frame_err, sample_sig, busy=0.
  - Reset mid-frame discards the partial word; no valid pulse.
- Synchroniser: two flops; `din_s` = second flop. Fixed latency of 2 edges from `din` to `din_s`.
- cnt width = clog2(SAMPLE_RATIO); bit index width = clog2(DATA_BITS+1).
- States and transitions:
  - IDLE: if din_s=0, go to START with cnt=0.
  - START: cnt++. When cnt=SAMPLE_RATIO/2-1:
    - din_s=0: go to DATA, cnt=0, idx=0.
    - din_s=1: glitch; return to IDLE with no output activity.
  - DATA: cnt counts 0..SAMPLE_RATIO-1 and wraps. At cnt=SAMPLE_RATIO-1: sample_sig=1, shift din_s into bit idx, idx++. After bit DATA_BITS-1, go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: one bit period; sample at cnt=SAMPLE_RATIO-1. parity_err_next = (XOR(data bits) ^ sampled bit) ≠ (PARITY_MODE==2).
  - STOP: STOP_BITS periods, sampled the same way; any 0 sets frame_err_next.
    - On the last stop sample: data<=word, data_valid<=1 for exactly one cycle, error flags registered alongside.
    - Next state: IDLE if the last stop bit=1, else BREAK.
  - BREAK: wait until din_s=1, then go to IDLE. This prevents a held-low line or break from retriggering frames.
- sample_sig is combinational: state∈{DATA, PARITY, STOP} and cnt=SAMPLE_RATIO-1. It is never asserted in IDLE, START or BREAK.
- Latency (SAMPLE_RATIO=16, 8N1), with edge E0 = first posedge at which din=0:
  - START entered at E2; DATA at E10.
  - Bit k is sampled at edge E26+16k; stop sampled at E154.
  - data_valid is high in the cycle after E154.
- Back-to-back frames: a start edge arriving immediately after a good stop bit is detected from IDLE; there are no dead cycles beyond the synchroniser.

Optional Feature:
- MAJORITY_VOTE_EN defined:
  - Each data, parity and stop bit takes the 2-of-3 majority of din_s at cnt = SAMPLE_RATIO-2, SAMPLE_RATIO-1 and the following edge.
  - The bit is committed one cycle later. data_valid is delayed by 1 cycle; sample_sig timing is unchanged.
  - The start-bit check remains a single sample.
- Undefined: single sample at cnt=SAMPLE_RATIO-1 as described above.

Test Plan:
- Defaults, send 0xA5 8N1, ideal timing -> data=0xA5, data_valid one cycle after E154, parity_err=0, frame_err=0, exactly 9 sample_sig pulses.
- din low for 5 cycles then high, no frame -> returns to IDLE at edge E10, busy drops, no sample_sig, no data_valid.
- PARITY_MODE=1, send 0x03 with parity bit 1 -> data=0x03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
- Stop bit 0 with din held low 40 cycles afterwards -> data_valid with frame_err=1; state stays BREAK until din_s=1; no spurious second frame.
- rst_n pulsed low at bit 4 of a frame, then a clean 0x3C frame -> no valid for the aborted frame; data=0x3C; all outputs 0 during reset.
- MAJORITY_VOTE_EN, single-cycle inverted glitch at cnt=SAMPLE_RATIO-1 on bit 2 of 0x00 -> data=0x00; without the macro -> data=0x04.
